// File: rtl/lu_elastic_pipe.sv
// ---------------------------------------------------------------------------
// lu_elastic_pipe
//
// Flow-control shell around a fixed-latency, non-stallable LU datapath.
// The datapath cannot be stalled, so this block admits a command token only
// when a slot is already reserved for its result in the output FIFO. Each
// result is paired with its tag, which travels through a matching delay line.
// The pair is then presented downstream with valid/ready. Results therefore
// never drop, even when the downstream write port applies backpressure.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   i_s_valid        command token valid
//   o_s_ready        a token can be accepted this cycle (registers only)
//   i_s_tag          token sideband (addresses, page, write-lane mask)
//   o_issue          token accepted, datapath operands launched this cycle
//   o_issue_tag      tag of the issued token
//   i_res_data       datapath result, valid LATENCY cycles after o_issue
//   o_m_valid        output FIFO head valid
//   i_m_ready        downstream ready
//   o_m_tag          tag at FIFO head
//   o_m_data         data at FIFO head
//   o_inflight       tokens issued whose result is not yet captured
//   o_fifo_count     entries held in the output FIFO
//   o_pipe_empty     nothing in flight and FIFO empty
// ---------------------------------------------------------------------------
module lu_elastic_pipe #(
  parameter int LATENCY = 23,
  parameter int DATA_W  = 256,
  parameter int TAG_W   = 16,
  parameter int DEPTH   = 32,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [TAG_W-1:0]  i_s_tag,
  output logic              o_issue,
  output logic [TAG_W-1:0]  o_issue_tag,
  input  logic [DATA_W-1:0] i_res_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [TAG_W-1:0]  o_m_tag,
  output logic [DATA_W-1:0] o_m_data,
  output logic [CNT_W-1:0]  o_inflight,
  output logic [CNT_W-1:0]  o_fifo_count,
  output logic              o_pipe_empty
);

  localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [LATENCY-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [LATENCY];

  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [TAG_W-1:0]   mem_tag_q  [DEPTH];
  logic [DATA_W-1:0]  mem_data_q [DEPTH];

  logic               accept;
  logic               capture;
  logic               pop;
  logic [CNT_W:0]     occupancy;

  // Pointer advance that wraps at DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Admission depends only on registered counts: every in-flight token
  // already owns a FIFO slot, so a capture can never find the FIFO full.
  assign occupancy    = {1'b0, inflight_q} + {1'b0, count_q};
  assign o_s_ready    = occupancy < DEPTH_SUM;
  assign accept       = i_s_valid & o_s_ready;
  assign o_issue      = accept;
  assign o_issue_tag  = i_s_tag;

  assign capture      = vld_q[LATENCY-1];
  assign o_m_valid    = count_q != '0;
  assign pop          = o_m_valid & i_m_ready;

  assign o_m_tag      = mem_tag_q[rd_ptr_q];
  assign o_m_data     = mem_data_q[rd_ptr_q];
  assign o_inflight   = inflight_q;
  assign o_fifo_count = count_q;
  assign o_pipe_empty = (inflight_q == '0) && (count_q == '0);

  // Next-state for counters and pointers; simultaneous inc/dec cancel.
  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({capture, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (capture) wr_ptr_d = ptrInc(wr_ptr_q);
    if (pop)     rd_ptr_d = ptrInc(rd_ptr_q);
  end

  // Control state. Clearing the valid line on reset guarantees that results
  // still emerging from the datapath afterwards are never captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Tag delay line and FIFO storage carry no reset; their contents are
  // qualified by vld_q and count_q respectively.
  always_ff @(posedge clk) begin
    tag_q[0] <= i_s_tag;
    for (int i = 1; i < LATENCY; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
    if (capture) begin
      mem_tag_q[wr_ptr_q]  <= tag_q[LATENCY-1];
      mem_data_q[wr_ptr_q] <= i_res_data;
    end
  end

`ifndef SYNTHESIS
  pushNotFull: assert property (@(posedge clk) disable iff (reset)
    capture |-> (count_q != DEPTH_CNT));

  inflightNoUnderflow: assert property (@(posedge clk) disable iff (reset)
    (capture && !accept) |-> (inflight_q != '0));

  headStableUnderStall: assert property (@(posedge clk) disable iff (reset)
    (o_m_valid && !i_m_ready) |=> ($stable(o_m_tag) && $stable(o_m_data)));
`endif

endmodule

// File: tb/tb_lu_elastic_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_lu_elastic_pipe
//
// Two instances share clock and reset: dutA (LATENCY=4, DEPTH=8) covers the
// basic, backpressure, random and reset scenarios. dutB (LATENCY=23, DEPTH=8)
// covers the throughput-limited case. Each instance has a tiny datapath model
// that returns {~tag, tag} exactly LATENCY cycles after issue. Each also has
// a scoreboard queue filled on issue and drained on every output handshake.
// ---------------------------------------------------------------------------
module tb_lu_elastic_pipe;

  localparam int TAG_W  = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int LAT_A  = 4;
  localparam int LAT_B  = 23;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic              sValidA, oSReadyA, oIssueA, oMValidA, mReadyA, oPipeEmptyA;
  logic [TAG_W-1:0]  tagA, oIssueTagA, oMTagA;
  logic [DATA_W-1:0] resDataA, oMDataA;
  logic [CNT_W-1:0]  oInflightA, oFifoCountA;

  logic              sValidB, oSReadyB, oIssueB, oMValidB, mReadyB, oPipeEmptyB;
  logic [TAG_W-1:0]  tagB, oIssueTagB, oMTagB;
  logic [DATA_W-1:0] resDataB, oMDataB;
  logic [CNT_W-1:0]  oInflightB, oFifoCountB;

  int total = 0;
  int bad   = 0;

  lu_elastic_pipe #(.LATENCY(LAT_A), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dutA (
    .clk(clk), .reset(reset),
    .i_s_valid(sValidA), .o_s_ready(oSReadyA), .i_s_tag(tagA),
    .o_issue(oIssueA), .o_issue_tag(oIssueTagA), .i_res_data(resDataA),
    .o_m_valid(oMValidA), .i_m_ready(mReadyA), .o_m_tag(oMTagA), .o_m_data(oMDataA),
    .o_inflight(oInflightA), .o_fifo_count(oFifoCountA), .o_pipe_empty(oPipeEmptyA)
  );

  lu_elastic_pipe #(.LATENCY(LAT_B), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dutB (
    .clk(clk), .reset(reset),
    .i_s_valid(sValidB), .o_s_ready(oSReadyB), .i_s_tag(tagB),
    .o_issue(oIssueB), .o_issue_tag(oIssueTagB), .i_res_data(resDataB),
    .o_m_valid(oMValidB), .i_m_ready(mReadyB), .o_m_tag(oMTagB), .o_m_data(oMDataB),
    .o_inflight(oInflightB), .o_fifo_count(oFifoCountB), .o_pipe_empty(oPipeEmptyB)
  );

  // Datapath models: the issued tag emerges as {~tag, tag} LATENCY cycles later.
  logic [TAG_W-1:0] dpA [LAT_A];
  logic [TAG_W-1:0] dpB [LAT_B];

  always @(posedge clk) begin
    dpA[0] <= oIssueTagA;
    for (int i = 1; i < LAT_A; i++) dpA[i] <= dpA[i-1];
    dpB[0] <= oIssueTagB;
    for (int i = 1; i < LAT_B; i++) dpB[i] <= dpB[i-1];
  end

  assign resDataA = {~dpA[LAT_A-1], dpA[LAT_A-1]};
  assign resDataB = {~dpB[LAT_B-1], dpB[LAT_B-1]};

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboards: expectation pushed at issue, compared at each handshake.
  logic [47:0] sbA [$];
  logic [47:0] sbB [$];
  logic [47:0] headA, headB;
  int          popsA = 0;

  always @(posedge clk) begin
    if (reset) begin
      sbA.delete();
      sbB.delete();
    end else begin
      if (oMValidA && mReadyA) begin
        popsA++;
        if (sbA.size() == 0) begin
          checkOutput("sbA_unexpected_output", 64'(oMTagA), 64'hDEAD);
        end else begin
          headA = sbA.pop_front();
          checkOutput("sbA_tag", 64'(oMTagA), 64'(headA[47:32]));
          checkOutput("sbA_data", 64'(oMDataA), 64'(headA[31:0]));
        end
      end
      if (oIssueA) sbA.push_back({tagA, ~tagA, tagA});
      if (oMValidB && mReadyB) begin
        if (sbB.size() == 0) begin
          checkOutput("sbB_unexpected_output", 64'(oMTagB), 64'hDEAD);
        end else begin
          headB = sbB.pop_front();
          checkOutput("sbB_tag", 64'(oMTagB), 64'(headB[47:32]));
          checkOutput("sbB_data", 64'(oMDataB), 64'(headB[31:0]));
        end
      end
      if (oIssueB) sbB.push_back({tagB, ~tagB, tagB});
    end
  end

  // Drive dutA inputs at the falling edge; outputs settle before the check.
  task automatic applyStimulus(input logic v, input logic [TAG_W-1:0] t, input logic r);
    @(negedge clk);
    sValidA = v;
    tagA    = t;
    mReadyA = r;
    #1;
  endtask

  task automatic waitEmptyA(input string name, input int maxCycles);
    for (int i = 0; i < maxCycles && !oPipeEmptyA; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput(name, 64'(oPipeEmptyA), 64'd1);
  endtask

  typedef struct {
    logic             sValid;
    logic [TAG_W-1:0] tag;
    logic             mReady;
    logic             expSReady;
    logic             expIssue;
    logic             expMValid;
    logic [CNT_W-1:0] expInflight;
    logic [CNT_W-1:0] expCount;
    logic             expEmpty;
    logic [TAG_W-1:0] expTag;
    logic [DATA_W-1:0] expData;
  } vecT;

  vecT vecs [7];
  int  accepts, peak, firstV, lastV, nextB, bestWin, win;
  int  acc [100];

  initial begin
    // Single token: issue at step 0, capture at step 4, visible at step 5.
    vecs[0] = '{1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0, 32'h0};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 16'h0, 32'h0};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 16'h0, 32'h0};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 16'h0, 32'h0};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 16'h0, 32'h0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 16'h0005, 32'hFFFA0005};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0, 32'h0};

    reset   = 1'b1;
    sValidA = 1'b0; tagA = '0; mReadyA = 1'b0;
    sValidB = 1'b0; tagB = '0; mReadyB = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_sready", 64'(oSReadyA), 64'd1);
    checkOutput("rst_issue", 64'(oIssueA), 64'd0);
    checkOutput("rst_mvalid", 64'(oMValidA), 64'd0);
    checkOutput("rst_inflight", 64'(oInflightA), 64'd0);
    checkOutput("rst_count", 64'(oFifoCountA), 64'd0);
    checkOutput("rst_empty", 64'(oPipeEmptyA), 64'd1);
    reset = 1'b0;
    repeat (5) applyStimulus(1'b0, '0, 1'b0);

    // Test 1: table-driven single token.
    for (int s = 0; s < 7; s++) begin
      applyStimulus(vecs[s].sValid, vecs[s].tag, vecs[s].mReady);
      checkOutput($sformatf("t1_sready[%0d]", s), 64'(oSReadyA), 64'(vecs[s].expSReady));
      checkOutput($sformatf("t1_issue[%0d]", s), 64'(oIssueA), 64'(vecs[s].expIssue));
      checkOutput($sformatf("t1_mvalid[%0d]", s), 64'(oMValidA), 64'(vecs[s].expMValid));
      checkOutput($sformatf("t1_inflight[%0d]", s), 64'(oInflightA), 64'(vecs[s].expInflight));
      checkOutput($sformatf("t1_count[%0d]", s), 64'(oFifoCountA), 64'(vecs[s].expCount));
      checkOutput($sformatf("t1_empty[%0d]", s), 64'(oPipeEmptyA), 64'(vecs[s].expEmpty));
      if (vecs[s].sValid)
        checkOutput($sformatf("t1_issue_tag[%0d]", s), 64'(oIssueTagA), 64'(vecs[s].tag));
      if (vecs[s].expMValid) begin
        checkOutput($sformatf("t1_mtag[%0d]", s), 64'(oMTagA), 64'(vecs[s].expTag));
        checkOutput($sformatf("t1_mdata[%0d]", s), 64'(oMDataA), 64'(vecs[s].expData));
      end
    end

    // Test 2: 100 back-to-back tokens with the sink always ready.
    peak = 0; firstV = -1; lastV = -1;
    popsA = 0;
    for (int k = 0; k < 112; k++) begin
      applyStimulus(k < 100, 16'(k), 1'b1);
      if (k < 100) checkOutput("t2_sready", 64'(oSReadyA), 64'd1);
      if (int'(oInflightA) > peak) peak = int'(oInflightA);
      if (oMValidA) begin
        if (firstV < 0) firstV = k;
        lastV = k;
      end
    end
    checkOutput("t2_peak_inflight", 64'(peak), 64'd4);
    checkOutput("t2_first_valid_step", 64'(firstV), 64'd5);
    checkOutput("t2_last_valid_step", 64'(lastV), 64'd104);
    checkOutput("t2_pops", 64'(popsA), 64'd100);
    waitEmptyA("t2_drain", 20);

    // Test 3: sink stalled, continuous valid.
    accepts = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 16'(200 + k), 1'b0);
      if (oIssueA) accepts++;
    end
    checkOutput("t3_accepts", 64'(accepts), 64'd8);
    checkOutput("t3_sready_full", 64'(oSReadyA), 64'd0);
    checkOutput("t3_count_full", 64'(oFifoCountA), 64'd8);
    checkOutput("t3_inflight_drained", 64'(oInflightA), 64'd0);
    applyStimulus(1'b1, 16'd300, 1'b1);
    checkOutput("t3_no_issue_when_full", 64'(oIssueA), 64'd0);
    applyStimulus(1'b1, 16'd300, 1'b0);
    checkOutput("t3_sready_after_pop", 64'(oSReadyA), 64'd1);
    checkOutput("t3_issue_after_pop", 64'(oIssueA), 64'd1);
    applyStimulus(1'b1, 16'd301, 1'b0);
    checkOutput("t3_sready_full_again", 64'(oSReadyA), 64'd0);
    waitEmptyA("t3_drain", 60);

    // Test 4: LATENCY=23, DEPTH=8 -> bursts of 8 every 25 cycles.
    nextB = 1000;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      sValidB = 1'b1;
      tagB    = 16'(nextB);
      #1;
      if (c == 0) checkOutput("t4_issue_tag", 64'(oIssueTagB), 64'(tagB));
      acc[c] = int'(oIssueB);
      if (oIssueB) nextB++;
    end
    @(negedge clk);
    sValidB = 1'b0;
    for (int i = 0; i < 100 && !oPipeEmptyB; i++) @(negedge clk);
    #1;
    checkOutput("t4_drain", 64'(oPipeEmptyB), 64'd1);
    checkOutput("t4_total_accepts", 64'(nextB - 1000), 64'd32);
    bestWin = 0;
    for (int s = 0; s + 24 <= 100; s++) begin
      win = 0;
      for (int j = 0; j < 24; j++) win += acc[s + j];
      if (win > bestWin) bestWin = win;
    end
    checkOutput("t4_max_per_24", 64'(bestWin), 64'd8);
    checkOutput("t4_sb_empty", 64'(sbB.size()), 64'd0);
    checkOutput("t4_inflight_zero", 64'(oInflightB), 64'd0);
    checkOutput("t4_count_zero", 64'(oFifoCountB), 64'd0);

    // Test 5: random traffic against the scoreboard.
    for (int k = 0; k < 10000; k++) begin
      applyStimulus($urandom_range(0, 99) < 50, 16'($urandom), $urandom_range(0, 99) < 30);
      checkOutput("t5_occupancy_bound",
                  64'((int'(oInflightA) + int'(oFifoCountA)) <= DEPTH), 64'd1);
    end
    waitEmptyA("t5_drain", 100);
    checkOutput("t5_sb_empty", 64'(sbA.size()), 64'd0);

    // Test 6: reset with 3 in flight and 5 queued.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 16'(500 + k), 1'b0);
    repeat (LAT_A + 1) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t6_count_pre", 64'(oFifoCountA), 64'd5);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'(600 + k), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t6_inflight_pre", 64'(oInflightA), 64'd3);
    checkOutput("t6_count_pre2", 64'(oFifoCountA), 64'd5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t6_inflight_rst", 64'(oInflightA), 64'd0);
    checkOutput("t6_count_rst", 64'(oFifoCountA), 64'd0);
    checkOutput("t6_mvalid_rst", 64'(oMValidA), 64'd0);
    checkOutput("t6_sready_rst", 64'(oSReadyA), 64'd1);
    checkOutput("t6_empty_rst", 64'(oPipeEmptyA), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < LAT_A + 2; k++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("t6_no_capture_mvalid", 64'(oMValidA), 64'd0);
      checkOutput("t6_no_capture_count", 64'(oFifoCountA), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
